// File: rtl/mont_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mont_pkg
//  Description : Shared definitions for the Montgomery conversion blocks:
//                controller state encoding and default operand geometry.
//                The default widths are shared by the entry and exit
//                converters so that they agree on R = 2^(n_len+1).
//  Revision    : 1.0 - initial release
// ============================================================================
package mont_pkg;

    // Default operand/modulus width in bits.
    localparam int MONT_WIDTH = 2048;
    // Default width of the modulus length field; 2^MONT_LEN_W >= MONT_WIDTH.
    localparam int MONT_LEN_W = 11;

    // Conversion controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        HALVE = 2'd2,
        DONE  = 2'd3
    } mont_state_t;

endpackage : mont_pkg
`default_nettype wire

// File: rtl/mont_halve_step.sv
`default_nettype none
// ============================================================================
//  Module      : mont_halve_step
//  Description : One combinational Montgomery halving step:
//                  o_half = (i_t + (i_t[0] ? i_n : 0)) >> 1
//                The addition is carried at WIDTH+1 bits so the carry out of
//                t + n is preserved. With n odd the sum is always even, so
//                the discarded LSB is always zero.
//  Ports       : i_t    [WIDTH-1:0]  running value
//                i_n    [WIDTH-1:0]  odd modulus
//                o_half [WIDTH-1:0]  halved result (< n when i_t < n)
//  Revision    : 1.0 - initial release
// ============================================================================
module mont_halve_step
    import mont_pkg::*;
#(
    parameter int WIDTH = MONT_WIDTH
) (
    input  logic [WIDTH-1:0] i_t,
    input  logic [WIDTH-1:0] i_n,
    output logic [WIDTH-1:0] o_half
);

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;
    logic             w_unused_lsb;

    // Adding n when t is odd makes the sum even, so the shift is exact.
    assign w_addend     = i_t[0] ? i_n : '0;
    assign w_sum        = {1'b0, i_t} + {1'b0, w_addend};
    assign o_half       = w_sum[WIDTH:1];
    assign w_unused_lsb = w_sum[0];

endmodule : mont_halve_step
`default_nettype wire

// File: rtl/mont_reduce.sv
`default_nettype none
// ============================================================================
//  Module      : mont_reduce
//  Description : Bit-serial conversion out of the Montgomery domain:
//                  result = x * 2^-(n_len+1) mod n
//                One conditional add-and-halve step per clock, k = n_len+1
//                steps in total. Operands are captured at start; the inputs
//                may change freely while the conversion runs.
//  Ports       : clk      rising-edge clock
//                rst      synchronous active-high reset
//                enable   start request, held high until finish is seen
//                x        Montgomery-domain operand (must be < n)
//                n        odd modulus
//                n_len    modulus length field, k = n_len + 1
//                result   x * 2^-k mod n, valid while finish = 1
//                finish   registered completion flag
//                err      precondition violation, valid while finish = 1
//  Revision    : 1.0 - initial release
// ============================================================================
module mont_reduce
    import mont_pkg::*;
#(
    parameter int WIDTH = MONT_WIDTH,
    parameter int LEN_W = MONT_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] n,
    input  logic [LEN_W-1:0] n_len,
    output logic [WIDTH-1:0] result,
    output logic             finish,
    output logic             err
);

    // Counter is one bit wider than n_len so that k = 2^LEN_W fits.
    localparam logic [LEN_W:0] c_CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

    mont_state_t      r_state;
    logic [WIDTH-1:0] r_t;
    logic [WIDTH-1:0] r_n;
    logic [LEN_W:0]   r_i;
    logic [WIDTH-1:0] r_result;
    logic             r_finish;
    logic             r_err;

    mont_state_t      w_state_nxt;
    logic [WIDTH-1:0] w_t_nxt;
    logic [WIDTH-1:0] w_n_nxt;
    logic [LEN_W:0]   w_i_nxt;
    logic [WIDTH-1:0] w_result_nxt;
    logic             w_finish_nxt;
    logic             w_err_nxt;
    logic [WIDTH-1:0] w_half;

    mont_halve_step #(
        .WIDTH (WIDTH)
    ) u_halve_step (
        .i_t    (r_t),
        .i_n    (r_n),
        .o_half (w_half)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_t      <= '0;
            r_n      <= '0;
            r_i      <= '0;
            r_result <= '0;
            r_finish <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_t      <= w_t_nxt;
            r_n      <= w_n_nxt;
            r_i      <= w_i_nxt;
            r_result <= w_result_nxt;
            r_finish <= w_finish_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_t_nxt      = r_t;
        w_n_nxt      = r_n;
        w_i_nxt      = r_i;
        w_result_nxt = r_result;
        w_finish_nxt = r_finish;
        w_err_nxt    = r_err;

        case (r_state)
            IDLE: begin
                w_finish_nxt = 1'b0;
                if (enable) begin
                    w_t_nxt     = x;
                    w_n_nxt     = n;
                    w_i_nxt     = {1'b0, n_len} + c_CNT_ONE;
                    w_state_nxt = CHECK;
                end
            end

            CHECK: begin
                // An even modulus or an unreduced operand breaks the t < n
                // invariant the halving loop relies on.
                if (!r_n[0] || (r_t >= r_n)) begin
                    w_err_nxt    = 1'b1;
                    w_result_nxt = '0;
                    w_finish_nxt = 1'b1;
                    w_state_nxt  = DONE;
                end else begin
                    w_err_nxt   = 1'b0;
                    w_state_nxt = HALVE;
                end
            end

            HALVE: begin
                w_t_nxt = w_half;
                w_i_nxt = r_i - c_CNT_ONE;
                // t stays below n at every step, so the last halving is
                // already fully reduced.
                if (r_i == c_CNT_ONE) begin
                    w_result_nxt = w_half;
                    w_finish_nxt = 1'b1;
                    w_state_nxt  = DONE;
                end
            end

            DONE: begin
                if (!enable) begin
                    w_finish_nxt = 1'b0;
                    w_state_nxt  = IDLE;
                end
            end

            default: begin
                w_state_nxt  = IDLE;
                w_finish_nxt = 1'b0;
            end
        endcase
    end

    assign result = r_result;
    assign finish = r_finish;
    assign err    = r_err;

endmodule : mont_reduce
`default_nettype wire

// File: tb/tb_mont_reduce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mont_reduce
//  Description : Self-checking bench for mont_reduce at WIDTH = 64,
//                LEN_W = 6 (so n_len = 63 is both full width and the
//                maximum halving count). Expected values come from a
//                modular-arithmetic model: x * inv(2)^k mod n, and the
//                Montgomery-entry map x * 2^k mod n for round trips.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mont_reduce;

    localparam int W  = 64;
    localparam int LW = 6;

    logic          clk;
    logic          rst;
    logic          enable;
    logic [W-1:0]  x;
    logic [W-1:0]  n;
    logic [LW-1:0] n_len;
    logic [W-1:0]  result;
    logic          finish;
    logic          err;

    int n_vec;
    int n_bad;

    mont_reduce #(
        .WIDTH (W),
        .LEN_W (LW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .x      (x),
        .n      (n),
        .n_len  (n_len),
        .result (result),
        .finish (finish),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  x;
        logic [W-1:0]  n;
        logic [LW-1:0] nlen;
        logic [W-1:0]  exp_res;
        logic          exp_err;
        int            exp_edge;
    } vec_t;

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] model_reduce(input logic [W-1:0] xv,
                                                  input logic [W-1:0] nv,
                                                  input int k);
        logic [127:0] inv2;
        logic [127:0] v;
        inv2 = ({64'b0, nv} + 128'd1) >> 1;
        v = {64'b0, xv};
        for (int j = 0; j < k; j++) v = (v * inv2) % {64'b0, nv};
        return v[W-1:0];
    endfunction

    function automatic logic [W-1:0] model_entry(input logic [W-1:0] xv,
                                                 input logic [W-1:0] nv,
                                                 input int k);
        logic [W:0] v;
        v = {1'b0, xv};
        for (int j = 0; j < k; j++) begin
            v = v << 1;
            if (v >= {1'b0, nv}) v = v - {1'b0, nv};
        end
        return v[W-1:0];
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts an operation from IDLE and waits for finish. Inputs are
    // scrambled after the start edge to show they are not resampled.
    task automatic run_op(input logic [W-1:0] xv, input logic [W-1:0] nv,
                          input logic [LW-1:0] lv,
                          output logic [W-1:0] res, output logic er,
                          output int edge_no);
        x = xv; n = nv; n_len = lv; enable = 1'b1;
        edge_no = -1;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (c == 0) begin
                x = {$urandom, $urandom};
                n = {$urandom, $urandom};
                n_len = LW'($urandom);
            end
            if (finish) begin
                edge_no = c;
                break;
            end
        end
        res = result;
        er  = err;
        if (edge_no < 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout: finish never rose, expected within 200 cycles");
            rst = 1'b1; tick(); rst = 1'b0;
        end
    endtask

    task automatic release_op(input string name);
        enable = 1'b0;
        tick();
        check(name, W'(finish), W'(0));
    endtask

    // ---------------- stimulus ----------------
    vec_t         tbl [7];
    logic [W-1:0] r_res;
    logic         r_er;
    int           r_edge;

    initial begin
        n_vec = 0; n_bad = 0;
        rst = 1'b1; enable = 1'b0; x = '0; n = '0; n_len = '0;

        tbl[0] = '{64'd2,  64'd13, 6'd3,  64'd5, 1'b0, 5};
        tbl[1] = '{64'd12, 64'd13, 6'd3,  64'd4, 1'b0, 5};
        tbl[2] = '{64'd0,  64'd13, 6'd3,  64'd0, 1'b0, 5};
        tbl[3] = '{64'd3,  64'd14, 6'd3,  64'd0, 1'b1, 1};
        tbl[4] = '{64'd13, 64'd13, 6'd3,  64'd0, 1'b1, 1};
        tbl[5] = '{64'd1,  {64{1'b1}}, 6'd63, 64'd1, 1'b0, 65};
        tbl[6] = '{64'd2,  64'd13, 6'd0,  64'd1, 1'b0, 2};

        // Reset state
        repeat (3) tick();
        check("reset_finish", W'(finish), W'(0));
        check("reset_result", result, W'(0));
        check("reset_err", W'(err), W'(0));
        rst = 1'b0;
        tick();

        // Directed table
        for (int v = 0; v < 7; v++) begin
            run_op(tbl[v].x, tbl[v].n, tbl[v].nlen, r_res, r_er, r_edge);
            check($sformatf("tbl%0d_result", v), r_res, tbl[v].exp_res);
            check($sformatf("tbl%0d_err", v), W'(r_er), W'(tbl[v].exp_err));
            check($sformatf("tbl%0d_edge", v), W'(r_edge), W'(tbl[v].exp_edge));
            release_op($sformatf("tbl%0d_release", v));
        end

        // Handshake: hold enable in DONE, drop, restart
        run_op(64'd2, 64'd13, 6'd3, r_res, r_er, r_edge);
        check("hs_first_result", r_res, 64'd5);
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("hs_hold%0d_finish", c), W'(finish), W'(1));
        end
        release_op("hs_drop");
        run_op(64'd2, 64'd13, 6'd3, r_res, r_er, r_edge);
        check("hs_restart_result", r_res, 64'd5);
        check("hs_restart_edge", W'(r_edge), W'(5));
        enable = 1'b0;
        tick();

        // Abort: reset sampled on the third HALVE edge (edge 4)
        x = 64'd2; n = 64'd13; n_len = 6'd3; enable = 1'b1;
        repeat (4) tick();   // edges 0..3
        check("abort_not_done", W'(finish), W'(0));
        rst = 1'b1;
        tick();              // edge 4
        check("abort_finish", W'(finish), W'(0));
        check("abort_result", result, W'(0));
        check("abort_err", W'(err), W'(0));
        rst = 1'b0; enable = 1'b0;
        tick();
        run_op(64'd12, 64'd13, 6'd3, r_res, r_er, r_edge);
        check("abort_restart_result", r_res, 64'd4);
        check("abort_restart_edge", W'(r_edge), W'(5));
        release_op("abort_restart_release");

        // Random round trips through the entry map, plus error cases
        for (int it = 0; it < 100; it++) begin
            logic [W-1:0]  rn;
            logic [W-1:0]  rx;
            logic [W-1:0]  ry;
            logic [LW-1:0] rl;
            int            k;
            rl = LW'($urandom_range(0, (1 << LW) - 1));
            k  = int'(rl) + 1;
            rn = {$urandom, $urandom};
            if (it % 10 == 9) begin
                rn[0] = 1'b0;
                rx = {$urandom, $urandom};
                run_op(rx, rn, rl, r_res, r_er, r_edge);
                check($sformatf("rnd%0d_err", it), W'(r_er), W'(1));
                check($sformatf("rnd%0d_result", it), r_res, W'(0));
                check($sformatf("rnd%0d_edge", it), W'(r_edge), W'(1));
            end else begin
                rn[0] = 1'b1;
                rx = {$urandom, $urandom} % rn;
                ry = model_entry(rx, rn, k);
                run_op(ry, rn, rl, r_res, r_er, r_edge);
                check($sformatf("rnd%0d_roundtrip", it), r_res, rx);
                check($sformatf("rnd%0d_model", it), r_res, model_reduce(ry, rn, k));
                check($sformatf("rnd%0d_err", it), W'(r_er), W'(0));
                check($sformatf("rnd%0d_edge", it), W'(r_edge), W'(k + 1));
            end
            release_op($sformatf("rnd%0d_release", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_mont_reduce
`default_nettype wire

// File: doc/mont_reduce.md
Name: mont_reduce

Overview:
Converts an operand out of the Montgomery domain: result = x · 2^-(n_len+1) mod n.
- Inverse of the Montgomery-entry conversion (x · 2^(n_len+1) mod n); shares the same radix R = 2^(n_len+1).
- Bit-serial: one conditional add-and-halve step per clock.
- Sits at the back end of the RSA datapath, after modular exponentiation, before the plaintext or ciphertext leaves the core.

Parameters:
- WIDTH, 2048, operand and modulus width in bits.
- LEN_W, 11, width of n_len; 2^LEN_W must be at least WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  start request; level-held four-phase handshake with finish.
- x  input  WIDTH  Montgomery-domain operand; precondition x < n.
- n  input  WIDTH  modulus; must be odd.
- n_len  input  LEN_W  modulus length field; halving count k = n_len + 1.
- result  output  WIDTH  x · 2^-k mod n; valid while finish = 1.
- finish  output  1  completion flag, registered.
- err  output  1  precondition violation flag, valid while finish = 1.

Behaviour:
- Single clock domain. Reset is synchronous and active-high and takes priority over all other logic: state ← IDLE, result ← 0, finish ← 0, err ← 0, counter ← 0.
- Internal state: t register of WIDTH bits, sum of WIDTH+1 bits, copies of n and x, counter i of LEN_W+1 bits.
- IDLE:
  - finish = 0.
  - On enable = 1: capture t ← x, n_r ← n, i ← n_len + 1; go to CHECK.
  - Inputs are not sampled again until the next start.
- CHECK (1 cycle):
  - If n_r[0] = 0 or t ≥ n_r: err ← 1, result ← 0, finish ← 1, go to DONE.
  - Otherwise err ← 0, go to HALVE.
- HALVE (exactly k cycles), per cycle:
  - sum = t + (t[0] ? n_r : 0), computed at WIDTH+1 bits so there is no overflow.
  - t ← sum >> 1; i ← i − 1.
  - Invariant t < n_r holds throughout, so no final subtraction is needed.
  - On the cycle where i = 1: result ← (sum >> 1)[WIDTH−1:0], finish ← 1, go to DONE.
- DONE:
  - finish stays 1; result and err hold.
  - When enable = 0: finish ← 0, go to IDLE. err clears at the next start.
  - result holds its last value until the next completion.
- Latency: the edge that samples enable in IDLE is edge 0. finish rises at edge n_len + 2 on success, or at edge 1 on an error.
- enable toggling while in CHECK or HALVE is ignored. Changing x, n or n_len mid-operation has no effect.
- Holding enable high in DONE keeps the block in DONE; no automatic restart.
- Extremes:
  - n_len = 0 gives k = 1, one HALVE cycle.
  - n_len = 2^LEN_W − 1 gives k = 2^LEN_W; the counter is LEN_W+1 bits wide, so this does not wrap.
- Reset asserted in any state aborts the operation in that cycle and returns to IDLE with all outputs zero.

Decomposition:
- Shared package mont_pkg holds:
  - state enum {IDLE, CHECK, HALVE, DONE};
  - default constants MONT_WIDTH = 2048 and MONT_LEN_W = 11, reused by the Montgomery-entry block.
- One natural sub-module: mont_halve_step, a combinational block that computes (t + t[0]·n) >> 1 at WIDTH+1 bits. It is reusable inside the Montgomery multiplier.

Test Plan:
- Basic reduction: n = 13, n_len = 3, x = 2 → t sequence 1, 7, 10, 5; result = 5, err = 0; finish rises at edge 5.
- Upper operand: n = 13, n_len = 3, x = 12 → result = 4. Boundary x = 0 → result = 0 after the same latency.
- Error paths:
  - n = 14, x = 3 → err = 1, result = 0, finish at edge 1.
  - n = 13, x = 13 → err = 1.
- Full width: n = 2^2048 − 1, n_len = 2047, x = 1 → result = 1; finish at edge 2049.
- Handshake: hold enable high 10 cycles in DONE → finish stays 1. Drop enable → finish = 0 next edge. Restart with x = 2 → result = 5 again.
- Abort: assert rst in cycle 3 of HALVE → next edge state IDLE, finish = 0, result = 0. A new start with x = 12 gives a correct result of 4.
- Round trip: x = 5 through the entry block (result 2), then through mont_reduce → result = 5. Repeat for 100 random odd n and x < n at WIDTH = 64.
